// File: rtl/pkt_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_det_pkg
// Description : Shared definitions for the packet detector.
//               - K-code symbol values (STP / END / EDB)
//               - detector FSM state encoding
//               - bit positions inside the one-hot tlp_type vector
//               - TLP Fmt / Type field codes
//               - byte-count width helper
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_det_pkg;

    // K-code symbols (valid only when dataK = 1)
    localparam logic [7:0] c_k_stp = 8'hFB;
    localparam logic [7:0] c_k_end = 8'hFD;
    localparam logic [7:0] c_k_edb = 8'hFE;

    // Detector FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DISCARD = 2'd2
    } det_state_e;

    // One-hot tlp_type bit positions
    localparam int c_tlp_w      = 10;
    localparam int c_tlp_mrd    = 0;
    localparam int c_tlp_mwr    = 1;
    localparam int c_tlp_iord   = 2;
    localparam int c_tlp_iowr   = 3;
    localparam int c_tlp_cfgrd0 = 4;
    localparam int c_tlp_cfgwr0 = 5;
    localparam int c_tlp_cfgrd1 = 6;
    localparam int c_tlp_cfgwr1 = 7;
    localparam int c_tlp_cpl    = 8;
    localparam int c_tlp_cpld   = 9;

    // Fmt[7:5] codes: 3DW/4DW header, without/with data
    localparam logic [2:0] c_fmt_3dw_nd = 3'b000;
    localparam logic [2:0] c_fmt_4dw_nd = 3'b001;
    localparam logic [2:0] c_fmt_3dw_d  = 3'b010;
    localparam logic [2:0] c_fmt_4dw_d  = 3'b011;

    // Type[4:0] codes
    localparam logic [4:0] c_type_mem  = 5'b00000;
    localparam logic [4:0] c_type_io   = 5'b00010;
    localparam logic [4:0] c_type_cfg0 = 5'b00100;
    localparam logic [4:0] c_type_cfg1 = 5'b00101;
    localparam logic [4:0] c_type_cpl  = 5'b01010;

    // Bits needed to hold a count in the range 0..max_count
    function automatic int byte_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_detector_v2_tlp_type_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tlp_type_decoder
// Description : Combinational decode of the TLP Fmt/Type byte into a one-hot
//               type vector. Unknown codes give an all-zero vector.
// Ports       : i_fmt_type [7:0]  Fmt[7:5] / Type[4:0] byte
//               o_tlp_type [9:0]  {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,
//                                  IOWr,IORd,MWr,MRd}
// Revision    : 1.0 - initial release
// ============================================================================
module tlp_type_decoder
    import pkt_det_pkg::*;
(
    input  logic [7:0]         i_fmt_type,
    output logic [c_tlp_w-1:0] o_tlp_type
);

    logic [2:0] w_fmt;
    logic [4:0] w_type;

    assign w_fmt  = i_fmt_type[7:5];
    assign w_type = i_fmt_type[4:0];

    always_comb begin
        o_tlp_type = '0;
        case (w_type)
            c_type_mem: begin
                // Memory requests come in both 3DW and 4DW header forms
                if (w_fmt == c_fmt_3dw_nd || w_fmt == c_fmt_4dw_nd)
                    o_tlp_type[c_tlp_mrd] = 1'b1;
                else if (w_fmt == c_fmt_3dw_d || w_fmt == c_fmt_4dw_d)
                    o_tlp_type[c_tlp_mwr] = 1'b1;
            end
            c_type_io: begin
                if (w_fmt == c_fmt_3dw_nd)     o_tlp_type[c_tlp_iord] = 1'b1;
                else if (w_fmt == c_fmt_3dw_d) o_tlp_type[c_tlp_iowr] = 1'b1;
            end
            c_type_cfg0: begin
                if (w_fmt == c_fmt_3dw_nd)     o_tlp_type[c_tlp_cfgrd0] = 1'b1;
                else if (w_fmt == c_fmt_3dw_d) o_tlp_type[c_tlp_cfgwr0] = 1'b1;
            end
            c_type_cfg1: begin
                if (w_fmt == c_fmt_3dw_nd)     o_tlp_type[c_tlp_cfgrd1] = 1'b1;
                else if (w_fmt == c_fmt_3dw_d) o_tlp_type[c_tlp_cfgwr1] = 1'b1;
            end
            c_type_cpl: begin
                if (w_fmt == c_fmt_3dw_nd)     o_tlp_type[c_tlp_cpl]  = 1'b1;
                else if (w_fmt == c_fmt_3dw_d) o_tlp_type[c_tlp_cpld] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pkt_detector_v2.sv
`default_nettype none
// ============================================================================
// Module      : pkt_detector_v2
// Description : Framed packet detector. Captures the bytes between STP and
//               END into PKT, decodes the TLP type from wire byte 2, counts
//               good packets and flags malformed ones.
// Ports       : clk, reset (sync, active-high)
//               data_valid, data_in[7:0], dataK   symbol stream
//               count_clr                         clear PKT_count
//               PKT, PKT_len, tlp_type            captured packet (held)
//               pkt_valid / pkt_err               one-cycle result pulses
//               PKT_count                         saturating good count
//               err_count, null_count             only with PKT_DET_STATS_EN
// Options     : `define PKT_DET_STATS_EN adds the error / nullify counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_detector_v2
    import pkt_det_pkg::*;
#(
    parameter int OUT_PKT_WIDTH = 256,
    parameter int PKT_CNT_WIDTH = 8,
    parameter int MIN_BYTES     = 18,
    parameter int STRIP_SEQ     = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       data_valid,
    input  logic [7:0]                                 data_in,
    input  logic                                       dataK,
    input  logic                                       count_clr,
    output logic [OUT_PKT_WIDTH-1:0]                   PKT,
    output logic [byte_cnt_width(OUT_PKT_WIDTH/8)-1:0] PKT_len,
    output logic                                       pkt_valid,
    output logic                                       pkt_err,
    output logic [c_tlp_w-1:0]                         tlp_type,
    output logic [PKT_CNT_WIDTH-1:0]                   PKT_count
`ifdef PKT_DET_STATS_EN
    ,
    output logic [PKT_CNT_WIDTH-1:0]                   err_count,
    output logic [PKT_CNT_WIDTH-1:0]                   null_count
`endif
);

    localparam int c_max_bytes = OUT_PKT_WIDTH / 8;
    localparam int c_len_w     = byte_cnt_width(c_max_bytes);
    // Wire count never exceeds MAX_BYTES+3 inside a capture; extra headroom
    // keeps the MIN_BYTES compare exact for any parameter mix.
    localparam int c_wire_w    = byte_cnt_width(c_max_bytes + MIN_BYTES + 2);

    det_state_e r_state;
    det_state_e w_state_next;

    logic [OUT_PKT_WIDTH-1:0] r_buf;
    logic [c_len_w-1:0]       r_stored;
    logic [c_wire_w-1:0]      r_wire_cnt;
    logic [c_tlp_w-1:0]       r_type;
    logic [c_tlp_w-1:0]       w_dec;

    logic w_is_stp, w_is_end, w_is_edb, w_is_data;
    logic w_keep, w_full, w_long_enough, w_type_byte;
    logic w_start, w_store, w_wire_inc, w_good, w_err;
    logic [OUT_PKT_WIDTH-1:0] w_byte_top;

    assign w_is_stp  = data_valid && dataK && (data_in == c_k_stp);
    assign w_is_end  = data_valid && dataK && (data_in == c_k_end);
    assign w_is_edb  = data_valid && dataK && (data_in == c_k_edb);
    assign w_is_data = data_valid && !dataK;

    // Sequence-number bytes (wire index 0 and 1) are optionally not stored
    if (STRIP_SEQ != 0) begin : g_strip_seq
        assign w_keep = (r_wire_cnt >= c_wire_w'(2));
    end else begin : g_keep_all
        assign w_keep = 1'b1;
    end

    assign w_full        = (r_stored == c_len_w'(c_max_bytes));
    assign w_long_enough = (r_wire_cnt >= c_wire_w'(MIN_BYTES));
    assign w_type_byte   = w_wire_inc && (r_wire_cnt == c_wire_w'(2));
    // Byte placed at the MSB end, then shifted down to its slot
    assign w_byte_top    = {data_in, {(OUT_PKT_WIDTH-8){1'b0}}};

    tlp_type_decoder u_tlp_type_decoder (
        .i_fmt_type (data_in),
        .o_tlp_type (w_dec)
    );

    // ------------------------------------------------------------------
    // Next-state and per-cycle action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_store      = 1'b0;
        w_wire_inc   = 1'b0;
        w_good       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_stp) begin
                    w_state_next = S_CAPTURE;
                    w_start      = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (w_is_stp) begin
                    // Restart: the interrupted packet is reported as bad
                    w_err   = 1'b1;
                    w_start = 1'b1;
                end else if (w_is_end) begin
                    w_state_next = S_IDLE;
                    if (w_long_enough) w_good = 1'b1;
                    else               w_err  = 1'b1;
                end else if (w_is_edb) begin
                    w_state_next = S_IDLE;
                end else if (w_is_data) begin
                    w_wire_inc = 1'b1;
                    if (w_keep) begin
                        if (w_full) begin
                            w_err        = 1'b1;
                            w_state_next = S_DISCARD;
                        end else begin
                            w_store = 1'b1;
                        end
                    end
                end
            end
            S_DISCARD: begin
                // Overflow was already reported; leave quietly
                if (w_is_stp) begin
                    w_state_next = S_CAPTURE;
                    w_start      = 1'b1;
                end else if (w_is_end || w_is_edb) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, capture buffer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_stored   <= '0;
            r_wire_cnt <= '0;
            r_type     <= '0;
            PKT        <= '0;
            PKT_len    <= '0;
            tlp_type   <= '0;
            pkt_valid  <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            pkt_valid <= w_good;
            pkt_err   <= w_err;
            if (w_start) begin
                r_buf      <= '0;
                r_stored   <= '0;
                r_wire_cnt <= '0;
                r_type     <= '0;
            end else begin
                if (w_wire_inc)
                    r_wire_cnt <= r_wire_cnt + 1'b1;
                if (w_store) begin
                    r_buf    <= r_buf | (w_byte_top >> {r_stored, 3'b000});
                    r_stored <= r_stored + 1'b1;
                end
                if (w_type_byte)
                    r_type <= w_dec;
            end
            // Published results only change on a good packet
            if (w_good) begin
                PKT      <= r_buf;
                PKT_len  <= r_stored;
                tlp_type <= r_type;
            end
        end
    end

    // Good-packet counter: saturating, clear has priority over increment
    always_ff @(posedge clk) begin
        if (reset || count_clr)
            PKT_count <= '0;
        else if (w_good && !(&PKT_count))
            PKT_count <= PKT_count + 1'b1;
    end

`ifdef PKT_DET_STATS_EN
    logic w_null;
    assign w_null = (r_state == S_CAPTURE) && w_is_edb;

    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            err_count  <= '0;
            null_count <= '0;
        end else begin
            if (w_err && !(&err_count))
                err_count <= err_count + 1'b1;
            if (w_null && !(&null_count))
                null_count <= null_count + 1'b1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_detector_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_detector_v2
// Description : Scoreboard bench for pkt_detector_v2. dut0 uses defaults,
//               dut1 uses STRIP_SEQ = 1. Stimulus tasks push the expected
//               pulse for each packet; per-DUT monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pkt_detector_v2;

    localparam int W  = 256;
    localparam int LW = 6;
    localparam int CW = 8;

    typedef struct {
        bit            is_err;
        logic [LW-1:0] len;
        logic [9:0]    typ;
        logic [CW-1:0] cnt;
        logic [W-1:0]  pkt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       dv  [2];
    logic       dk  [2];
    logic       clr [2];
    logic [7:0] din [2];

    logic [W-1:0]  pkt0, pkt1;
    logic [LW-1:0] len0, len1;
    logic          pv0, pv1, pe0, pe1;
    logic [9:0]    typ0, typ1;
    logic [CW-1:0] cnt0, cnt1;
`ifdef PKT_DET_STATS_EN
    logic [CW-1:0] ec0, ec1, nc0, nc1;
`endif

    pkt_detector_v2 u_dut0 (
        .clk(clk), .reset(reset), .data_valid(dv[0]), .data_in(din[0]),
        .dataK(dk[0]), .count_clr(clr[0]), .PKT(pkt0), .PKT_len(len0),
        .pkt_valid(pv0), .pkt_err(pe0), .tlp_type(typ0), .PKT_count(cnt0)
`ifdef PKT_DET_STATS_EN
        , .err_count(ec0), .null_count(nc0)
`endif
    );

    pkt_detector_v2 #(.STRIP_SEQ(1)) u_dut1 (
        .clk(clk), .reset(reset), .data_valid(dv[1]), .data_in(din[1]),
        .dataK(dk[1]), .count_clr(clr[1]), .PKT(pkt1), .PKT_len(len1),
        .pkt_valid(pv1), .pkt_err(pe1), .tlp_type(typ1), .PKT_count(cnt1)
`ifdef PKT_DET_STATS_EN
        , .err_count(ec1), .null_count(nc1)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   exp_count [2];
    bit   open_cap  [2];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_err(input int s);
        exp_t e;
        e.is_err = 1'b1; e.len = '0; e.typ = '0; e.pkt = '0;
        e.cnt = CW'(exp_count[s]);
        push(s, e);
    endtask

    task automatic push_valid(input int s, input int len, input logic [9:0] typ,
                              input logic [W-1:0] p, input bit clr_now);
        exp_t e;
        if (clr_now)                exp_count[s] = 0;
        else if (exp_count[s] < 255) exp_count[s]++;
        e.is_err = 1'b0; e.len = LW'(len); e.typ = typ; e.pkt = p;
        e.cnt = CW'(exp_count[s]);
        push(s, e);
    endtask

    // One input cycle: set inputs now (at a negedge), hold to next negedge
    task automatic cyc(input int s, input logic v, input logic k,
                       input logic [7:0] d, input logic c);
        dv[s] = v; dk[s] = k; din[s] = d; clr[s] = c;
        @(negedge clk);
    endtask

    // term: 0 = END, 1 = EDB, 2 = none (packet left open)
    task automatic send_pkt(input int s, input int n, input logic [7:0] b2,
                            input logic [9:0] typ, input int term,
                            input bit clr_end, input bit gaps);
        logic [W-1:0] ep;
        logic [7:0]   b;
        int           stored;
        bit           ovf;
        ep = '0; stored = 0; ovf = 1'b0;
        if (gaps && !open_cap[s]) cyc(s, 1'b1, 1'b0, 8'h55, 1'b0);
        if (open_cap[s]) push_err(s);
        cyc(s, 1'b1, 1'b1, 8'hFB, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i < 2)       b = 8'(i);
            else if (i == 2) b = b2;
            else             b = 8'h10 + 8'(i);
            if (!(s == 1 && i < 2) && !ovf) begin
                if (stored == 32) begin
                    push_err(s);
                    ovf = 1'b1;
                end else begin
                    ep[W-1-8*stored -: 8] = b;
                    stored++;
                end
            end
            cyc(s, 1'b1, 1'b0, b, 1'b0);
            if (gaps && (i % 5 == 4)) begin
                cyc(s, 1'b0, 1'b1, 8'hFB, 1'b0);
                cyc(s, 1'b1, 1'b1, 8'hBC, 1'b0);
            end
        end
        open_cap[s] = 1'b0;
        case (term)
            0: begin
                if (!ovf) begin
                    if (n >= 18) push_valid(s, stored, typ, ep, clr_end);
                    else         push_err(s);
                end
                cyc(s, 1'b1, 1'b1, 8'hFD, clr_end);
            end
            1: cyc(s, 1'b1, 1'b1, 8'hFE, 1'b0);
            default: open_cap[s] = !ovf;
        endcase
        cyc(s, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_q0", W'(q0.size()), '0);
        check("drain_q1", W'(q1.size()), '0);
        q0.delete();
        q1.delete();
    endtask

    task automatic mon(input int s, input logic pv, input logic pe,
                       input logic [LW-1:0] len, input logic [9:0] typ,
                       input logic [CW-1:0] cnt, input logic [W-1:0] p);
        exp_t e;
        int   qs;
        if (pv && pe) begin
            checks++; errors++;
            $display("FAIL dut%0d valid_err_overlap actual=both required=one", s);
        end
        if (pv || pe) begin
            qs = (s == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++; errors++;
                $display("FAIL dut%0d unexpected_pulse actual valid=%0b err=%0b required none", s, pv, pe);
            end else begin
                if (s == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("dut%0d pulse_is_err", s), W'(pe), W'(e.is_err));
                check($sformatf("dut%0d pulse_count", s), W'(cnt), W'(e.cnt));
                if (!e.is_err) begin
                    check($sformatf("dut%0d pkt_len", s), W'(len), W'(e.len));
                    check($sformatf("dut%0d tlp_type", s), W'(typ), W'(e.typ));
                    check($sformatf("dut%0d pkt_data", s), p, e.pkt);
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, pv0, pe0, len0, typ0, cnt0, pkt0);
    always @(negedge clk) mon(1, pv1, pe1, len1, typ1, cnt1, pkt1);

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            dv[s] = 1'b0; dk[s] = 1'b0; din[s] = 8'h00; clr[s] = 1'b0;
            exp_count[s] = 0; open_cap[s] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pkt",   pkt0, '0);
        check("reset_len",   W'(len0), '0);
        check("reset_type",  W'(typ0), '0);
        check("reset_count", W'(cnt0), '0);
        check("reset_valid", W'(pv0), '0);
        check("reset_err",   W'(pe0), '0);
        reset = 1'b0;
        @(negedge clk);

        // Good packets across the type table
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        drain();
        check("count_after_first", W'(cnt0), W'(8'd1));
        send_pkt(0, 20, 8'h00, 10'h001, 0, 1'b0, 1'b1);
        send_pkt(0, 19, 8'h44, 10'h020, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h7F, 10'h000, 0, 1'b0, 1'b0);
        send_pkt(0, 32, 8'h0A, 10'h100, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h25, 10'h000, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h60, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h05, 10'h040, 0, 1'b0, 1'b0);
        drain();

        // Short packets, nullified packet
        send_pkt(0, 10, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 17, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 20, 8'h40, 10'h002, 1, 1'b0, 1'b0);
        drain();
        check("count_after_short", W'(cnt0), W'(8'd8));
        check("len_held",  W'(len0), W'(6'd18));
        check("type_held", W'(typ0), W'(10'h040));

        // Overflow then recovery
        send_pkt(0, 33, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 40, 8'h40, 10'h002, 1, 1'b0, 1'b0);
        drain();

        // STP aborts from CAPTURE and from DISCARD
        send_pkt(0, 5,  8'h40, 10'h002, 2, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h42, 10'h008, 0, 1'b0, 1'b0);
        send_pkt(0, 34, 8'h40, 10'h002, 2, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h02, 10'h004, 0, 1'b0, 1'b0);
        drain();
        check("count_after_abort", W'(cnt0), W'(8'd11));

        // Saturation, then clear coinciding with an increment
        while (exp_count[0] < 255) send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        drain();
        check("count_saturated", W'(cnt0), W'(8'hFF));
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b1, 1'b0);
        drain();
        check("count_clear_wins", W'(cnt0), '0);

        // Reset in the middle of a capture
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        drain();
        cyc(0, 1'b1, 1'b1, 8'hFB, 1'b0);
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        reset = 1'b1;
        cyc(0, 1'b1, 1'b0, 8'h36, 1'b0);
        reset = 1'b0;
        exp_count[0] = 0; exp_count[1] = 0;
        open_cap[0] = 1'b0; open_cap[1] = 1'b0;
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("midreset_pkt",   pkt0, '0);
        check("midreset_count", W'(cnt0), '0);
        send_pkt(0, 18, 8'h40, 10'h002, 0, 1'b0, 1'b0);
        drain();
        check("count_after_midreset", W'(cnt0), W'(8'd1));

        // Sequence stripping on dut1
        send_pkt(1, 18, 8'h4A, 10'h200, 0, 1'b0, 1'b0);
        drain();
        check("strip_first_byte", W'(pkt1[255:248]), W'(8'h4A));
        check("strip_len",        W'(len1), W'(6'd16));
        check("strip_type",       W'(typ1), W'(10'h200));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_detector_v2.md
PKT_DETECTOR_V2 -- requirements
Module: pkt_detector_v2

Interface
REQ-001 Parameter OUT_PKT_WIDTH, default 256, captured-packet register width in bits; SHALL be a multiple of 8, so MAX_BYTES = OUT_PKT_WIDTH/8.
REQ-002 Parameter PKT_CNT_WIDTH, default 8, width of the good-packet counter.
REQ-003 Parameter MIN_BYTES, default 18, minimum legal wire bytes between STP and END (2 seq + 12 hdr + 4 LCRC).
REQ-004 Parameter STRIP_SEQ, default 0; when 1, the two sequence-number bytes are not stored in PKT.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 data_valid  in  1  data_in/dataK qualify this cycle.
REQ-008 data_in  in  8  symbol byte.
REQ-009 dataK  in  1  1 = data_in is a K-character.
REQ-010 count_clr  in  1  synchronous clear of PKT_count.
REQ-011 PKT  out  OUT_PKT_WIDTH  captured packet; first stored byte at bits [OUT_PKT_WIDTH-1 -: 8]; unused LSBs zero.
REQ-012 PKT_len  out  clog2(MAX_BYTES+1)  number of stored bytes in PKT.
REQ-013 pkt_valid  out  1  one-cycle pulse; PKT, PKT_len and tlp_type are valid.
REQ-014 pkt_err  out  1  one-cycle pulse on a malformed packet.
REQ-015 tlp_type  out  10  one-hot {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}; all-zero = unknown type.
REQ-016 PKT_count  out  PKT_CNT_WIDTH  good-packet count.

Function
REQ-017 K-codes: STP = 8'hFB, END = 8'hFD, EDB = 8'hFE (dataK = 1); other K-chars are ignored in every state. Cycles with data_valid = 0 are ignored and hold all state.
REQ-018 FSM states: IDLE, CAPTURE, DISCARD.
- IDLE --STP--> CAPTURE.
- Non-K bytes in IDLE are ignored.
REQ-019 CAPTURE: each data byte increments the wire byte count. Bytes are stored in arrival order unless STRIP_SEQ = 1 and the byte index is less than 2.
REQ-020 The Fmt/Type byte is wire byte index 2 and is decoded as follows:
- Fmt[7:5] 000/001 with Type 00000 = MRd; 010/011 with Type 00000 = MWr.
- Fmt 000 / 010 with Type 00010 = IORd / IOWr.
- Fmt 000 / 010 with Type 00100 = CfgRd0 / CfgWr0.
- Fmt 000 / 010 with Type 00101 = CfgRd1 / CfgWr1.
- Fmt 000 / 010 with Type 01010 = Cpl / CplD.
- Any other code = all-zero tlp_type.
REQ-021 END in CAPTURE with wire count >= MIN_BYTES: pkt_valid pulses the cycle after END is accepted, PKT_count increments, and the FSM returns to IDLE.
REQ-022 END in CAPTURE with wire count < MIN_BYTES: pkt_err pulses the next cycle, PKT_count is unchanged, and the FSM returns to IDLE.
REQ-023 The (MAX_BYTES+1)-th stored byte: pkt_err pulses the next cycle and the FSM enters DISCARD. DISCARD stays until END/EDB, then goes to IDLE with no further pulse.
REQ-024 EDB in CAPTURE nullifies the packet: no pkt_valid, no pkt_err, no count change; the FSM goes to IDLE.
REQ-025 STP in CAPTURE or DISCARD aborts the current packet and restarts capture with a zeroed count.
- Abort from CAPTURE pulses pkt_err.
- Abort from DISCARD does not pulse pkt_err.
REQ-026 PKT_count saturates at all-ones. If count_clr and an increment occur in the same cycle, the result is 0 (clear wins).
REQ-027 PKT, PKT_len and tlp_type hold their last values until the next pkt_valid.
REQ-028 pkt_valid and pkt_err SHALL never be asserted in the same cycle.

Reset
REQ-029 reset = 1 on a clock edge: FSM to IDLE; PKT, PKT_len, tlp_type, PKT_count, pkt_valid and pkt_err all 0.
REQ-030 Reset during CAPTURE drops the partial packet silently; reset takes priority over all inputs.

Configuration
REQ-031 Macro PKT_DET_STATS_EN defined: adds outputs err_count and null_count (PKT_CNT_WIDTH each).
- err_count counts pkt_err pulses; null_count counts EDB nullifications.
- Both saturate, are cleared by count_clr, and reset to 0.
REQ-032 Macro undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 Package pkt_det_pkg SHALL hold:
- the K-code constants;
- the FSM state enum;
- the tlp_type bit-index constants;
- the Fmt/Type code constants;
- a byte-count width function.
REQ-034 Sub-module tlp_type_decoder: combinational, Fmt/Type byte in, 10-bit one-hot out. It is instantiated once and its result is registered on the wire-index-2 byte.

Verification
REQ-035 STP, 18 bytes with byte2 = 8'h40, END: pkt_valid 1 cycle after END; tlp_type = MWr; PKT_len = 18; PKT_count = 1.
REQ-036 STRIP_SEQ = 1, STP, seq 8'h00 8'h01, byte2 = 8'h4A, 15 more bytes, END: PKT[255:248] = 8'h4A; PKT_len = 16; tlp_type = CplD.
REQ-037 STP, 10 bytes, END: pkt_err pulses; PKT_count unchanged. STP, 20 bytes, EDB: no pulse at all.
REQ-038 STP, 33 bytes (MAX_BYTES = 32), END: a single pkt_err pulse after byte 33; the next good packet is detected normally.
REQ-039 PKT_count = 8'hFF plus one good packet: stays 8'hFF. count_clr coinciding with an increment gives 0.
REQ-040 reset asserted at byte 7 of a capture, then a full good packet: exactly one pkt_valid, and PKT_count = 1.
